piso_framer: RTL

PISO_FRAMER -- requirements
Module: piso_framer

---
 rtl/piso_framer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/piso_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : piso_framer
//  Description: Parallel-in / serial-out framer. Words arrive on a
//               valid/ready handshake into a one-word hold register. They are
//               then moved into a shift register and emitted one bit per
//               enabled clock as a framed serial stream. The stream carries
//               frame_start on the first bit and ser_last on the final bit.
//               While the hold register stays full, frames follow each other
//               with no gap.
//
//  Parameters : WIDTH      - parallel word width in bits (2..16)
//               MSB_FIRST  - 1: bit WIDTH-1 goes out first, 0: bit 0 first
//
//  Ports      : clk          in   rising-edge clock
//               rst          in   asynchronous active-high reset
//               en           in   shift enable (serialiser advances only when 1)
//               parallel     in   word to serialise [WIDTH-1:0]
//               par_valid    in   parallel holds a valid word
//               par_ready    out  block accepts a word this cycle
//               serial       out  registered serial bit
//               ser_valid    out  serial carries a frame bit this cycle
//               frame_start  out  first bit of a frame
//               ser_last     out  last bit of a frame
//
//  Compile-time option:
//               PISO_PARITY_EN - when defined, each frame is followed by an
//                                even-parity bit, which carries ser_last.
//
//  Revision   : 1.0  initial release
// ============================================================================
module piso_framer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] parallel,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             serial,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             ser_last
);

    // Counter reaches WIDTH at most (one past the last data bit).
    localparam int unsigned        CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   c_cnt_last = CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_shift  = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] c_st_parity = 2'd2;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q,       state_d;
    logic [WIDTH-1:0] hold_q,        hold_d;
    logic             hold_full_q,   hold_full_d;
    logic [WIDTH-1:0] shreg_q,       shreg_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic             serial_q,      serial_d;
    logic             ser_valid_q,   ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             ser_last_q,    ser_last_d;
`ifdef PISO_PARITY_EN
    logic             parity_q,      parity_d;
`endif

    logic             w_accept;
    logic             w_load;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shifted;

    // par_ready depends only on a flop, so no combinational path from
    // par_valid exists. A word freed on this edge can only be replaced
    // from the next cycle onward.
    assign w_accept = par_valid & ~hold_full_q;

    // Bit selection and shift direction are fixed by MSB_FIRST.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_next_bit = shreg_q[WIDTH-1];
            assign w_shifted  = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_next_bit = shreg_q[0];
            assign w_shifted  = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        serial_d      = serial_q;
        // Frame strobes are single-cycle: low unless a bit goes out now.
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        ser_last_d    = 1'b0;
        w_load        = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d      = parity_q;
`endif

        // Accept only happens while the hold register is empty. Load only
        // happens while it is full. The two can never collide on hold_full.
        if (w_accept) begin
            hold_d      = parallel;
            hold_full_d = 1'b1;
        end

        case (state_q)
            c_st_idle: begin
                // The transfer into the shift register does not wait for en.
                if (hold_full_q) begin
                    w_load = 1'b1;
                end
            end

            c_st_shift: begin
                if (en) begin
                    serial_d      = w_next_bit;
                    ser_valid_d   = 1'b1;
                    frame_start_d = (cnt_q == '0);
                    shreg_d       = w_shifted;
                    cnt_d         = cnt_q + 1'b1;
                    if (cnt_q == c_cnt_last) begin
`ifdef PISO_PARITY_EN
                        state_d = c_st_parity;
`else
                        ser_last_d = 1'b1;
                        // Reloading on the last data bit keeps frames gapless.
                        if (hold_full_q) begin
                            w_load = 1'b1;
                        end else begin
                            state_d = c_st_idle;
                        end
`endif
                    end
                end
            end

`ifdef PISO_PARITY_EN
            c_st_parity: begin
                if (en) begin
                    serial_d    = parity_q;
                    ser_valid_d = 1'b1;
                    ser_last_d  = 1'b1;
                    if (hold_full_q) begin
                        w_load = 1'b1;
                    end else begin
                        state_d = c_st_idle;
                    end
                end
            end
`endif

            default: begin
                state_d = c_st_idle;
            end
        endcase

        // Move the held word into the shift register and start a new frame.
        if (w_load) begin
            state_d     = c_st_shift;
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
`ifdef PISO_PARITY_EN
            // Even parity over the data bits is fixed once the word is known.
            parity_d    = ^hold_q;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= c_st_idle;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            shreg_q       <= '0;
            cnt_q         <= '0;
            serial_q      <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            ser_last_q    <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            serial_q      <= serial_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            ser_last_q    <= ser_last_d;
`ifdef PISO_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign par_ready   = ~hold_full_q;
    assign serial      = serial_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign ser_last    = ser_last_q;

endmodule
`default_nettype wire
